// File: rtl/inst_fetch_queue_pkg.sv
// Shared constants and entry layout for the instruction fetch queue.
package inst_fetch_queue_pkg;

    localparam int unsigned IFQ_DEPTH      = 8;
    localparam int unsigned IFQ_PTR_W      = 3;
    localparam int unsigned IFQ_PC_W       = 32;
    localparam int unsigned IFQ_INST_W     = 32;
    localparam int unsigned IFQ_PADDR_W    = 32;
    localparam int unsigned IFQ_ENTRY_W    = IFQ_PC_W + IFQ_INST_W + 1 + IFQ_PADDR_W;

    // One queued instruction: 97 bits packed, pc in the MSBs.
    typedef struct packed {
        logic [IFQ_PC_W-1:0]    pc;
        logic [IFQ_INST_W-1:0]  inst;
        logic                   pred_taken;
        logic [IFQ_PADDR_W-1:0] pred_addr;
    } ifq_entry_t;

    // Smaller of two 2-bit quantities (used to clamp the decode pop request).
    function automatic logic [1:0] ifq_min2(input logic [1:0] a, input logic [1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Fetch/decode side signals of the instruction fetch queue.
interface inst_fetch_queue_if;
    import inst_fetch_queue_pkg::*;

    logic        flush;
    logic        in_valid1;
    logic        in_valid2;
    logic [31:0] in_pc1;
    logic [31:0] in_pc2;
    logic [31:0] in_inst1;
    logic [31:0] in_inst2;
    logic        in_pred_taken1;
    logic        in_pred_taken2;
    logic [31:0] in_pred_addr1;
    logic [31:0] in_pred_addr2;
    logic        in_ready;
    logic        out_valid1;
    logic        out_valid2;
    logic [31:0] out_pc1;
    logic [31:0] out_inst1;
    logic        out_pred_taken1;
    logic [31:0] out_pred_addr1;
    logic [31:0] out_pc2;
    logic [31:0] out_inst2;
    logic        out_pred_taken2;
    logic [31:0] out_pred_addr2;
    logic [1:0]  dec_pop_cnt;
    logic [31:0] stall_cycles;

    // Fetch/decode environment driving the queue.
    modport master (
        output flush, in_valid1, in_valid2, in_pc1, in_pc2, in_inst1, in_inst2,
               in_pred_taken1, in_pred_taken2, in_pred_addr1, in_pred_addr2, dec_pop_cnt,
        input  in_ready, out_valid1, out_valid2,
               out_pc1, out_inst1, out_pred_taken1, out_pred_addr1,
               out_pc2, out_inst2, out_pred_taken2, out_pred_addr2, stall_cycles
    );

    // The queue itself.
    modport slave (
        input  flush, in_valid1, in_valid2, in_pc1, in_pc2, in_inst1, in_inst2,
               in_pred_taken1, in_pred_taken2, in_pred_addr1, in_pred_addr2, dec_pop_cnt,
        output in_ready, out_valid1, out_valid2,
               out_pc1, out_inst1, out_pred_taken1, out_pred_addr1,
               out_pc2, out_inst2, out_pred_taken2, out_pred_addr2, stall_cycles
    );

endinterface

// File: rtl/inst_fetch_queue_ifq_entry_ram.sv
// Entry storage: DEPTH x 97-bit registers, two write ports, two async read ports, no reset.
module ifq_entry_ram
    import inst_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = IFQ_DEPTH,
    parameter int unsigned PTR_W = IFQ_PTR_W
) (
    input  logic             clk_i,
    input  logic             we0_i,
    input  logic [PTR_W-1:0] waddr0_i,
    input  ifq_entry_t       wdata0_i,
    input  logic             we1_i,
    input  logic [PTR_W-1:0] waddr1_i,
    input  ifq_entry_t       wdata1_i,
    input  logic [PTR_W-1:0] raddr0_i,
    output ifq_entry_t       rdata0_o,
    input  logic [PTR_W-1:0] raddr1_i,
    output ifq_entry_t       rdata1_o
);

    ifq_entry_t mem_q [DEPTH];

    // Write ports; the top never targets the same address on both in one cycle.
    always_ff @(posedge clk_i) begin
        if (we0_i) mem_q[waddr0_i] <= wdata0_i;
        if (we1_i) mem_q[waddr1_i] <= wdata1_i;
    end

    assign rdata0_o = mem_q[raddr0_i];
    assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/inst_fetch_queue.sv
// Dual-issue instruction fetch queue: up to two pushes and two in-order pops per cycle.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = IFQ_DEPTH,
    parameter int unsigned PTR_W = IFQ_PTR_W
) (
    input  logic                cpu_clk,
    input  logic                cpu_rstn,
    inst_fetch_queue_if.slave   bus
);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [31:0]      stall_q, stall_d;

    logic             ready;
    logic             v2_eff;
    logic [1:0]       push_n;
    logic [1:0]       pop_req;
    logic [1:0]       pop_n;
    logic             we0, we1;
    ifq_entry_t       slot1, slot2, wdata0;
    ifq_entry_t       rd0, rd1;

    assign ready  = (count_q <= (PTR_W+1)'(DEPTH - 2));
    // A slot-2 instruction behind a predicted-taken slot 1 is wrong-path.
    assign v2_eff = bus.in_valid2 & ~(bus.in_valid1 & bus.in_pred_taken1);

    assign slot1 = '{pc: bus.in_pc1, inst: bus.in_inst1,
                     pred_taken: bus.in_pred_taken1, pred_addr: bus.in_pred_addr1};
    assign slot2 = '{pc: bus.in_pc2, inst: bus.in_inst2,
                     pred_taken: bus.in_pred_taken2, pred_addr: bus.in_pred_addr2};

    // Compaction: port 0 always writes the oldest valid slot at tail, port 1 writes slot 2 at tail+1.
    always_comb begin
        we0    = 1'b0;
        we1    = 1'b0;
        wdata0 = bus.in_valid1 ? slot1 : slot2;
        push_n = 2'd0;
        if (ready && !bus.flush && !cpu_rstn) begin
            we0    = bus.in_valid1 | v2_eff;
            we1    = bus.in_valid1 & v2_eff;
            push_n = 2'(bus.in_valid1) + 2'(v2_eff);
        end
    end

    // Pop clamped to the request (max 2) and to the registered occupancy.
    always_comb begin
        pop_req = ifq_min2(bus.dec_pop_cnt, 2'd2);
        pop_n   = pop_req;
        if (count_q < (PTR_W+1)'(pop_req)) pop_n = count_q[1:0];
    end

    // Next-state pointers, occupancy and stall counter; flush empties the queue.
    always_comb begin
        head_d  = head_q + PTR_W'(pop_n);
        tail_d  = tail_q + PTR_W'(push_n);
        count_d = count_q + (PTR_W+1)'(push_n) - (PTR_W+1)'(pop_n);
        stall_d = stall_q;
        if (bus.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else if ((bus.in_valid1 | bus.in_valid2) && !ready) begin
            stall_d = stall_q + 32'd1;
        end
    end

    // State registers with synchronous reset (reset wins over flush and push).
    always_ff @(posedge cpu_clk) begin
        if (cpu_rstn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            stall_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            stall_q <= stall_d;
        end
    end

    ifq_entry_ram #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ram (
        .clk_i    (cpu_clk),
        .we0_i    (we0),
        .waddr0_i (tail_q),
        .wdata0_i (wdata0),
        .we1_i    (we1),
        .waddr1_i (tail_q + PTR_W'(1)),
        .wdata1_i (slot2),
        .raddr0_i (head_q),
        .rdata0_o (rd0),
        .raddr1_i (head_q + PTR_W'(1)),
        .rdata1_o (rd1)
    );

    assign bus.in_ready        = ready;
    assign bus.out_valid1      = (count_q != '0);
    assign bus.out_valid2      = (count_q >= (PTR_W+1)'(2));
    assign bus.out_pc1         = bus.out_valid1 ? rd0.pc         : '0;
    assign bus.out_inst1       = bus.out_valid1 ? rd0.inst       : '0;
    assign bus.out_pred_taken1 = bus.out_valid1 ? rd0.pred_taken : 1'b0;
    assign bus.out_pred_addr1  = bus.out_valid1 ? rd0.pred_addr  : '0;
    assign bus.out_pc2         = bus.out_valid2 ? rd1.pc         : '0;
    assign bus.out_inst2       = bus.out_valid2 ? rd1.inst       : '0;
    assign bus.out_pred_taken2 = bus.out_valid2 ? rd1.pred_taken : 1'b0;
    assign bus.out_pred_addr2  = bus.out_valid2 ? rd1.pred_addr  : '0;
    assign bus.stall_cycles    = stall_q;

endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Dual-issue instruction queue between the fetch stage (PC, BPU prediction, I-cache return) and decode. Each cycle it accepts up to two fetched instructions with their PC and branch prediction, and presents up to two oldest entries to decode in program order. It decouples fetch bubbles from decode stalls and is emptied on any redirect.

## Interface

Parameters:
- DEPTH, 8 — entry count; power of two, ≥4
- PTR_W, 3 — log2(DEPTH)

Ports:
- cpu_clk  in  1  — clock
- cpu_rstn  in  1  — synchronous reset; active-high despite the name (codebase naming)
- flush  in  1  — redirect (BPU_flush or exception); empties queue
- in_valid1 / in_valid2  in  1  — fetch slot 1/2 valid; slot 1 is older
- in_pc1 / in_pc2  in  32  — slot PCs
- in_inst1 / in_inst2  in  32  — instruction words
- in_pred_taken1 / in_pred_taken2  in  1  — BPU taken prediction per slot
- in_pred_addr1 / in_pred_addr2  in  32  — BPU predicted next PC per slot
- in_ready  out  1  — queue can accept two entries this cycle
- out_valid1 / out_valid2  out  1  — head / head+1 entry present
- out_pc1, out_inst1, out_pred_taken1, out_pred_addr1  out  32/32/1/32  — head entry
- out_pc2, out_inst2, out_pred_taken2, out_pred_addr2  out  32/32/1/32  — head+1 entry
- dec_pop_cnt  in  2  — entries consumed by decode this cycle (0, 1 or 2)
- stall_cycles  out  32  — perf counter: cycles with (in_valid1|in_valid2) & !in_ready

## Operation

- State: entry array [DEPTH], head, tail (PTR_W bits, wrap mod DEPTH), count (PTR_W+1 bits).
- in_ready = (count ≤ DEPTH−2), from registered count only; same-cycle pop does not raise it.
- Push only when in_ready. Effective slot-2 valid = in_valid2 & !(in_valid1 & in_pred_taken1) (wrong-path slot after predicted-taken slot 1 is dropped).
- Valid slots written compacted at tail in order: both → tail, tail+1; only one (either slot) → tail. tail advances by number written (0–2).
- Pop: effective pop = min(dec_pop_cnt, count); head advances by it. dec_pop_cnt=2 with count=1 pops 1; any pop with count=0 is ignored.
- count_next = count + pushed − popped; simultaneous push and pop legal, including at count = DEPTH−2 and count = 0 (no bypass: a pushed entry is not poppable the same cycle).
- out_valid1 = (count≥1), out_valid2 = (count≥2); data read combinationally from array[head], array[head+1 mod DEPTH]. Data outputs forced to 0 when their valid is low.
- flush: highest priority; next cycle head=tail=count=0; same-cycle push and pop discarded. stall_cycles unaffected by flush.
- stall_cycles increments by 1 per stall cycle, wraps at 2^32; not incremented in a flush cycle.

## Timing

- Reset (cpu_rstn=1 at edge): head=tail=count=0, stall_cycles=0; hence out_valid1/2=0, all out data=0, in_ready=1. Array contents not reset. Reset overrides flush and push.
- Push→output latency 1 cycle: entry written at edge N is visible on out_* after edge N.
- Pop takes effect at the edge; next entries appear the following cycle.
- in_ready changes only after a clock edge.
- Flush asserted in cycle N: out_valid1/2=0 and in_ready=1 from cycle N+1; push in N+1 is accepted normally.

## Structure

- defines.vh: IFQ_DEPTH, IFQ_PTR_W, entry field widths/offsets (pc 32, inst 32, pred_taken 1, pred_addr 32 = 97-bit packed entry).
- One sub-module natural: ifq_entry_ram — DEPTH×97 register array, two write ports (write-enable + address each), two asynchronous read ports; no reset. Top holds pointers, count, push/pop logic and perf counter.

## Test plan

- Reset then two pushes of both slots (pc 0x1c000000/04/08/0c), no pop → count 4; out_pc1=0x1c000000, out_pc2=0x1c000004; in_ready=1.
- Push slot1 pred_taken=1 pred_addr=0x1c000100 with slot2 valid → only one entry written; out_valid2=0 next cycle.
- Fill to DEPTH−1 (=7) → in_ready=0; push attempt ignored, stall_cycles +1 per cycle; pop 2 → in_ready=1 next cycle.
- Steady push 2 / pop 2 across pointer wrap for 20 cycles → PCs emerge strictly sequential, no loss or duplication.
- count=1 with dec_pop_cnt=2 → count 0, head advances 1; pop on empty → no change.
- Flush in same cycle as push and pop with count=5 → next cycle count 0, out_valid1=0, out data 0; reset mid-fill equivalent plus stall_cycles=0.
